// File: rtl/vx_scoreboard_slice_pkg.sv
// Shared constants, parameter helpers and the scoreboard register-bundle type
// used by the scoreboard slice and its interface.
package vx_scoreboard_slice_pkg;

  localparam int NR_BITS  = 5;
  localparam int NUM_REGS = 1 << NR_BITS;

  function automatic int log2up(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  function automatic int issue_cnt(input int warps);
    return (warps < 4) ? warps : 4;
  endfunction

  // Register-usage part of a scoreboard entry; wis/tmask widths depend on
  // module parameters and travel alongside it.
  typedef struct packed {
    logic               wb;
    logic [NR_BITS-1:0] rd;
    logic [NR_BITS-1:0] rs1;
    logic [NR_BITS-1:0] rs2;
    logic [NR_BITS-1:0] rs3;
  } sb_regs_t;

endpackage

// File: rtl/vx_scoreboard_slice_if.sv
// Instruction-in, writeback and instruction-out streams of one scoreboard slice.
interface vx_scoreboard_slice_if
  import vx_scoreboard_slice_pkg::*;
#(
  parameter int THREAD_CNT = 4,
  parameter int WIS_W      = 1,
  parameter int PAYLOADW   = 1
) ();

  logic                  ibuf_valid;
  logic                  ibuf_ready;
  logic [WIS_W-1:0]      ibuf_wis;
  logic [THREAD_CNT-1:0] ibuf_tmask;
  logic                  ibuf_wb;
  logic [NR_BITS-1:0]    ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
  logic [PAYLOADW-1:0]   ibuf_payload;

  logic                  wb_valid;
  logic [WIS_W-1:0]      wb_wis;
  logic [NR_BITS-1:0]    wb_rd;
  logic                  wb_eop;

  logic                  out_valid;
  logic                  out_ready;
  logic [WIS_W-1:0]      out_wis;
  logic [THREAD_CNT-1:0] out_tmask;
  logic                  out_wb;
  logic [NR_BITS-1:0]    out_rd, out_rs1, out_rs2, out_rs3;
  logic [PAYLOADW-1:0]   out_payload;

  modport master (
    output ibuf_valid, ibuf_wis, ibuf_tmask, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2,
           ibuf_rs3, ibuf_payload, wb_valid, wb_wis, wb_rd, wb_eop, out_ready,
    input  ibuf_ready, out_valid, out_wis, out_tmask, out_wb, out_rd, out_rs1,
           out_rs2, out_rs3, out_payload
  );

  modport slave (
    input  ibuf_valid, ibuf_wis, ibuf_tmask, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2,
           ibuf_rs3, ibuf_payload, wb_valid, wb_wis, wb_rd, wb_eop, out_ready,
    output ibuf_ready, out_valid, out_wis, out_tmask, out_wb, out_rd, out_rs1,
           out_rs2, out_rs3, out_payload
  );

endinterface

// File: rtl/vx_scoreboard_slice.sv
// One issue slice of the register scoreboard: tracks in-flight destination
// registers per warp, blocks dependent instructions and registers the issue.
module vx_scoreboard_slice
  import vx_scoreboard_slice_pkg::*;
#(
  parameter int THREAD_CNT    = 4,
  parameter int WARP_CNT      = 4,
  parameter int ISSUE_CNT     = issue_cnt(WARP_CNT),
  parameter int PAYLOADW      = 1,
  parameter int STALL_TIMEOUT = 100000,
  localparam int ISSUE_RATIO  = WARP_CNT / ISSUE_CNT,
  localparam int ISSUE_WIS_W  = log2up(ISSUE_RATIO)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  vx_scoreboard_slice_if.slave sb,
  output logic [31:0]          o_perf_stalls,
  output logic                 o_timeout
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

  logic [ISSUE_RATIO-1:0][NUM_REGS-1:0] r_inuse;
  logic                  r_out_valid;
  logic [ISSUE_WIS_W-1:0] r_out_wis;
  logic [THREAD_CNT-1:0] r_out_tmask;
  sb_regs_t              r_out_regs;
  logic [PAYLOADW-1:0]   r_out_payload;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [31:0]           r_perf_stalls;
  logic                  r_timeout;

  logic [NUM_REGS-1:0]   w_row;
  logic                  w_hazard, w_ready, w_accept, w_stall;

  // Row select by loop keeps the lookup legal when ISSUE_RATIO is 1.
  always_comb begin
    w_row = '0;
    for (int w = 0; w < ISSUE_RATIO; w++)
      if (sb.ibuf_wis == ISSUE_WIS_W'(w)) w_row = r_inuse[w];
  end

  assign w_hazard = sb.ibuf_valid & (w_row[sb.ibuf_rs1] | w_row[sb.ibuf_rs2] |
                    w_row[sb.ibuf_rs3] | (sb.ibuf_wb & w_row[sb.ibuf_rd]));
  assign w_ready  = ~i_reset & ~w_hazard & (~r_out_valid | sb.out_ready);
  assign w_accept = sb.ibuf_valid & w_ready;
  assign w_stall  = sb.ibuf_valid & ~w_ready;

  // Clear is scheduled before set so a same-entry collision leaves the bit set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_inuse <= '0;
    end else begin
      for (int w = 0; w < ISSUE_RATIO; w++) begin
        if (sb.wb_valid && sb.wb_eop && sb.wb_wis == ISSUE_WIS_W'(w))
          r_inuse[w][sb.wb_rd] <= 1'b0;
        if (w_accept && sb.ibuf_wb && sb.ibuf_rd != '0 && sb.ibuf_wis == ISSUE_WIS_W'(w))
          r_inuse[w][sb.ibuf_rd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)         r_out_valid <= 1'b0;
    else if (w_accept)   r_out_valid <= 1'b1;
    else if (sb.out_ready) r_out_valid <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_out_wis     <= sb.ibuf_wis;
      r_out_tmask   <= sb.ibuf_tmask;
      r_out_regs    <= '{wb: sb.ibuf_wb, rd: sb.ibuf_rd, rs1: sb.ibuf_rs1,
                         rs2: sb.ibuf_rs2, rs3: sb.ibuf_rs3};
      r_out_payload <= sb.ibuf_payload;
    end
  end

  // Stall run length saturates at the limit; the timeout flag is sticky.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt   <= '0;
      r_perf_stalls <= '0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_stall) r_perf_stalls <= r_perf_stalls + 32'd1;
      if (!w_stall) r_stall_cnt <= '0;
      else if (r_stall_cnt != CNT_W'(STALL_TIMEOUT)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_stall && r_stall_cnt == CNT_W'(STALL_TIMEOUT - 1)) r_timeout <= 1'b1;
    end
  end

  assign sb.ibuf_ready  = w_ready;
  assign sb.out_valid   = r_out_valid;
  assign sb.out_wis     = r_out_wis;
  assign sb.out_tmask   = r_out_tmask;
  assign sb.out_wb      = r_out_regs.wb;
  assign sb.out_rd      = r_out_regs.rd;
  assign sb.out_rs1     = r_out_regs.rs1;
  assign sb.out_rs2     = r_out_regs.rs2;
  assign sb.out_rs3     = r_out_regs.rs3;
  assign sb.out_payload = r_out_payload;
  assign o_perf_stalls  = r_perf_stalls;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_vx_scoreboard_slice.sv
// Scoreboard slice bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_vx_scoreboard_slice;
  import vx_scoreboard_slice_pkg::*;

  localparam int TC = 4, WC = 8, IC = 4, RATIO = 2, WISW = 1, PW = 8, TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] perf;
  logic        tmo;

  always #5 clk = ~clk;

  vx_scoreboard_slice_if #(.THREAD_CNT(TC), .WIS_W(WISW), .PAYLOADW(PW)) sbif ();

  vx_scoreboard_slice #(
    .THREAD_CNT(TC), .WARP_CNT(WC), .ISSUE_CNT(IC), .PAYLOADW(PW), .STALL_TIMEOUT(TO)
  ) u_dut (
    .i_clk(clk), .i_reset(rst), .sb(sbif), .o_perf_stalls(perf), .o_timeout(tmo)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [WISW-1:0]    wis;
    logic [TC-1:0]      tmask;
    logic               wb;
    logic [NR_BITS-1:0] rd, rs1, rs2, rs3;
    logic [PW-1:0]      pl;
  } instr_t;

  bit          m_busy[RATIO][NUM_REGS];
  bit          m_ov   = 0;
  instr_t      m_out;
  int unsigned m_perf = 0;
  int          m_run  = 0;
  bit          m_tmo  = 0;

  always @(negedge clk) begin
    bit     haz, rdy, acc;
    instr_t cur;
    cur = '{sbif.ibuf_wis, sbif.ibuf_tmask, sbif.ibuf_wb, sbif.ibuf_rd,
            sbif.ibuf_rs1, sbif.ibuf_rs2, sbif.ibuf_rs3, sbif.ibuf_payload};
    haz = sbif.ibuf_valid && (m_busy[cur.wis][cur.rs1] || m_busy[cur.wis][cur.rs2] ||
          m_busy[cur.wis][cur.rs3] || (cur.wb && m_busy[cur.wis][cur.rd]));
    rdy = !rst && !haz && (!m_ov || sbif.out_ready);

    chk("ibuf_ready", sbif.ibuf_ready, rdy);
    chk("out_valid", sbif.out_valid, m_ov);
    if (m_ov)
      chk("out_fields", {sbif.out_wis, sbif.out_tmask, sbif.out_wb, sbif.out_rd,
          sbif.out_rs1, sbif.out_rs2, sbif.out_rs3, sbif.out_payload}, m_out);
    chk("perf_stalls", perf, m_perf);
    chk("timeout", tmo, m_tmo);

    if (rst) begin
      foreach (m_busy[w, r]) m_busy[w][r] = 0;
      m_ov = 0; m_perf = 0; m_run = 0; m_tmo = 0;
    end else begin
      acc = sbif.ibuf_valid && rdy;
      if (sbif.ibuf_valid && !rdy) begin
        m_perf++;
        m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run >= TO) m_tmo = 1;
      if (acc) begin m_out = cur; m_ov = 1; end
      else if (sbif.out_ready) m_ov = 0;
      if (sbif.wb_valid && sbif.wb_eop) m_busy[sbif.wb_wis][sbif.wb_rd] = 0;
      if (acc && cur.wb && cur.rd != 0) m_busy[cur.wis][cur.rd] = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int wis, input int rd, input bit wb, input int rs1,
                       input int rs2 = 0, input int rs3 = 0);
    sbif.ibuf_valid   = 1'b1;
    sbif.ibuf_wis     = WISW'(wis);
    sbif.ibuf_rd      = NR_BITS'(rd);
    sbif.ibuf_wb      = wb;
    sbif.ibuf_rs1     = NR_BITS'(rs1);
    sbif.ibuf_rs2     = NR_BITS'(rs2);
    sbif.ibuf_rs3     = NR_BITS'(rs3);
    sbif.ibuf_tmask   = TC'($urandom);
    sbif.ibuf_payload = PW'($urandom);
  endtask

  task automatic wback(input bit v, input int wis, input int rd, input bit eop);
    sbif.wb_valid = v;
    sbif.wb_wis   = WISW'(wis);
    sbif.wb_rd    = NR_BITS'(rd);
    sbif.wb_eop   = eop;
  endtask

  logic [NR_BITS-1:0] held_rd;
  logic [PW-1:0]      held_pl;

  initial begin
    issue(0, 0, 0, 0);
    sbif.ibuf_valid = 1'b0;
    wback(0, 0, 0, 0);
    sbif.out_ready = 1'b1;

    // reset: ibuf_ready must be low even with a hazard-free request
    cyc();
    issue(0, 0, 0, 0);
    #1 chk("ready_in_reset", sbif.ibuf_ready, 1'b0);
    cyc();
    chk("reset_out_valid", sbif.out_valid, 1'b0);
    chk("reset_perf", perf, 32'd0);
    rst = 1'b0;

    // cycle 1: producer of r5
    issue(0, 5, 1, 0);
    #1 chk("c1_ready", sbif.ibuf_ready, 1'b1);
    cyc();
    // cycle 2: consumer of r5 stalls until writeback edge has passed
    chk("c2_out_valid", sbif.out_valid, 1'b1);
    chk("c2_out_rd", sbif.out_rd, 5'd5);
    issue(0, 0, 0, 5);
    #1 chk("c2_ready", sbif.ibuf_ready, 1'b0);
    cyc();
    cyc();
    wback(1, 0, 5, 1);
    #1 chk("c4_no_bypass", sbif.ibuf_ready, 1'b0);
    cyc();
    wback(0, 0, 0, 0);
    #1 chk("c5_ready", sbif.ibuf_ready, 1'b1);
    cyc();
    chk("c6_out_valid", sbif.out_valid, 1'b1);
    chk("c6_out_rs1", sbif.out_rs1, 5'd5);
    chk("c6_perf", perf, 32'd3);

    // warp isolation: warp0 owns r6, warp1 reading r6 is not blocked
    issue(0, 6, 1, 0);
    cyc();
    issue(1, 0, 0, 6);
    #1 chk("warp1_free", sbif.ibuf_ready, 1'b1);
    cyc();

    // backpressure: output held, no accept
    sbif.out_ready = 1'b0;
    issue(1, 3, 0, 1);
    held_rd = sbif.out_rd;
    held_pl = sbif.out_payload;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", sbif.ibuf_ready, 1'b0);
      cyc();
      chk("bp_hold_rd", sbif.out_rd, held_rd);
      chk("bp_hold_pl", sbif.out_payload, held_pl);
    end
    sbif.out_ready = 1'b1;
    #1 chk("bp_release", sbif.ibuf_ready, 1'b1);
    cyc();
    issue(1, 4, 0, 2);
    #1 chk("back_to_back", sbif.ibuf_ready, 1'b1);
    cyc();

    // non-eop writeback keeps r6 busy; rd=0 never becomes busy
    wback(1, 0, 6, 0);
    issue(0, 0, 0, 6);
    cyc();
    wback(0, 0, 0, 0);
    #1 chk("no_eop_keeps", sbif.ibuf_ready, 1'b0);
    issue(0, 0, 1, 1);
    cyc();
    issue(0, 0, 0, 0, 0, 0);
    #1 chk("r0_never_busy", sbif.ibuf_ready, 1'b1);
    cyc();
    wback(1, 0, 6, 1);
    sbif.ibuf_valid = 1'b0;
    cyc();
    wback(0, 0, 0, 0);

    // stall timeout
    issue(0, 7, 1, 0);
    cyc();
    issue(0, 0, 0, 7);
    for (int i = 0; i < 7; i++) cyc();
    chk("tmo_before", tmo, 1'b0);
    cyc();
    chk("tmo_at_limit", tmo, 1'b1);
    wback(1, 0, 7, 1);
    cyc();
    wback(0, 0, 0, 0);
    sbif.ibuf_valid = 1'b0;
    issue(0, 9, 1, 0);
    cyc();
    sbif.ibuf_valid = 1'b0;
    cyc();
    chk("tmo_sticky", tmo, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("tmo_reset", tmo, 1'b0);
    chk("rst_out_valid", sbif.out_valid, 1'b0);
    issue(0, 0, 0, 9);
    #1 chk("rst_clears_inuse", sbif.ibuf_ready, 1'b1);
    cyc();

    // randomized traffic, small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      issue($urandom_range(0, 1), $urandom_range(0, 7), 1'($urandom),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      sbif.ibuf_valid = ($urandom_range(0, 9) < 7);
      sbif.out_ready  = ($urandom_range(0, 3) != 0);
      wback($urandom_range(0, 9) < 4, $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;
    sbif.ibuf_valid = 1'b0;
    wback(0, 0, 0, 0);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
